// File: rtl/sub_share_arbiter_pkg.sv
// sub_arb_pkg: shared FSM state type, ID-width helper and default operand width
package sub_arb_pkg;

    localparam int DEF_DATAWIDTH = 10;

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting at the pointer
module rr_picker
    import sub_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     winner_o,
    output logic               any_req_o
);

    logic [IDW-1:0] idx;

    assign any_req_o = |req_i;

    // scan from the farthest offset back to the pointer so the closest requester wins
    always_comb begin
        winner_o = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDW'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx]) winner_o = idx;
        end
    end

endmodule

// File: rtl/sub_share_arbiter_sub.sv
// sub_dp: shared unsigned modulo subtractor datapath component
module sub_dp #(
    parameter int DATAWIDTH = 10
) (
    input  logic [DATAWIDTH-1:0] a_i,
    input  logic [DATAWIDTH-1:0] b_i,
    output logic [DATAWIDTH-1:0] y_o
);

    assign y_o = a_i - b_i;

endmodule

// File: rtl/sub_share_arbiter.sv
// sub_share_arbiter: round-robin sequencer time-sharing one subtractor among requesters
module sub_share_arbiter
    import sub_arb_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int NUM_REQ = 4,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   a_in,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   b_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [DATAWIDTH-1:0]           diff,
    output logic                           borrow,
    output logic [IDW-1:0]                 diff_id,
    output logic                           diff_valid,
    input  logic                           diff_ready,
    output logic                           busy
);

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d, cur_id_q, cur_id_d, diff_id_q, diff_id_d, win;
    logic [DATAWIDTH-1:0] opa_q, opa_d, opb_q, opb_d, diff_q, diff_d, sub_y;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 borrow_q, borrow_d, valid_q, valid_d, any_req;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i(req),
        .ptr_i(rr_q),
        .winner_o(win),
        .any_req_o(any_req)
    );

    sub_dp #(.DATAWIDTH(DATAWIDTH)) u_sub (
        .a_i(opa_q),
        .b_i(opb_q),
        .y_o(sub_y)
    );

    assign gnt        = gnt_q;
    assign diff       = diff_q;
    assign borrow     = borrow_q;
    assign diff_id    = diff_id_q;
    assign diff_valid = valid_q;
    assign busy       = (state_q == EXEC) || (state_q == HOLD);

    // state and datapath registers; reset drops any in-flight or held result
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            cur_id_q  <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            gnt_q     <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            diff_id_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cur_id_q  <= cur_id_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            gnt_q     <= gnt_d;
            diff_q    <= diff_d;
            borrow_q  <= borrow_d;
            diff_id_q <= diff_id_d;
            valid_q   <= valid_d;
        end
    end

    // EXEC captures the result; IDLE or an accepted HOLD arbitrates; a stalled HOLD keeps everything
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cur_id_d  = cur_id_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        gnt_d     = '0;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        diff_id_d = diff_id_q;
        valid_d   = valid_q;
        if (state_q == EXEC) begin
            diff_d    = sub_y;
            borrow_d  = opa_q < opb_q;
            diff_id_d = cur_id_q;
            valid_d   = 1'b1;
            state_d   = HOLD;
        end else if (!(state_q == HOLD && !diff_ready)) begin
            valid_d = 1'b0;
            state_d = IDLE;
            if (any_req) begin
                opa_d    = a_in[int'(win)*DATAWIDTH +: DATAWIDTH];
                opb_d    = b_in[int'(win)*DATAWIDTH +: DATAWIDTH];
                cur_id_d = win;
                gnt_d    = NUM_REQ'(1) << win;
                rr_d     = (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                state_d  = EXEC;
            end
        end
    end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// tb_sub_share_arbiter: directed and randomized checks against a transaction-level model
module tb_sub_share_arbiter;

    localparam int DW = 10;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] a_in = '0;
    logic [N*DW-1:0] b_in = '0;
    logic            diff_ready = 1'b0;
    logic [N-1:0]    gnt;
    logic [DW-1:0]   diff;
    logic            borrow;
    logic [IW-1:0]   diff_id;
    logic            diff_valid;
    logic            busy;

    int n_chk = 0;
    int n_fail = 0;

    // reference model: what is in flight, who is next in line, what was computed
    int m_phase = 0;
    int m_ptr = 0;
    int m_cur = 0;
    int m_a = 0;
    int m_b = 0;
    int e_gnt = 0;
    int e_valid = 0;
    int e_diff = 0;
    int e_borrow = 0;
    int e_id = 0;

    int grants[$];

    sub_share_arbiter #(.DATAWIDTH(DW), .NUM_REQ(N)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .req(req),
        .a_in(a_in),
        .b_in(b_in),
        .gnt(gnt),
        .diff(diff),
        .borrow(borrow),
        .diff_id(diff_id),
        .diff_valid(diff_valid),
        .diff_ready(diff_ready),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_in[i*DW +: DW] = DW'(a);
        b_in[i*DW +: DW] = DW'(b);
    endtask

    task automatic model_edge();
        int w;
        e_gnt = 0;
        if (Rst) begin
            m_phase = 0; m_ptr = 0; e_valid = 0; e_diff = 0; e_borrow = 0; e_id = 0;
        end else if (m_phase == 1) begin
            e_diff = m_a - m_b;
            if (e_diff < 0) e_diff += (1 << DW);
            e_borrow = (m_a < m_b) ? 1 : 0;
            e_id = m_cur;
            e_valid = 1;
            m_phase = 2;
        end else if (m_phase == 0 || diff_ready) begin
            e_valid = 0;
            m_phase = 0;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_a = int'(a_in[w*DW +: DW]);
                m_b = int'(b_in[w*DW +: DW]);
                m_cur = w;
                m_ptr = (w + 1) % N;
                e_gnt = 1 << w;
                m_phase = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("valid", 32'(diff_valid), 32'(e_valid));
        check("busy", 32'(busy), (m_phase != 0) ? 1 : 0);
        if (e_valid != 0) begin
            check("diff", 32'(diff), 32'(e_diff));
            check("borrow", 32'(borrow), 32'(e_borrow));
            check("diff_id", 32'(diff_id), 32'(e_id));
        end
        for (int k = 0; k < N; k++) if (gnt[k]) grants.push_back(k);
    endtask

    task automatic do_reset(input int cycles);
        Rst = 1'b1;
        repeat (cycles) cyc();
        Rst = 1'b0;
    endtask

    initial begin
        // reset with all requests high: nothing granted, outputs cleared
        req = 4'b1111;
        do_reset(2);
        check("rst_diff", 32'(diff), 0);
        check("rst_borrow", 32'(borrow), 0);
        check("rst_id", 32'(diff_id), 0);
        check("rst_gnt", 32'(gnt), 0);
        cyc();
        check("first_gnt_req0", 32'(gnt), 32'h1);
        req = '0;
        diff_ready = 1'b1;
        repeat (4) cyc();

        // single operation on requester 2
        set_op(2, 25, 7);
        req = 4'b0100;
        cyc();
        check("single_gnt", 32'(gnt), 32'h4);
        req = '0;
        cyc();
        check("single_diff", 32'(diff), 18);
        check("single_borrow", 32'(borrow), 0);
        check("single_id", 32'(diff_id), 2);
        check("single_valid", 32'(diff_valid), 1);
        repeat (2) cyc();

        // round-robin order and wrap after reset
        do_reset(1);
        grants.delete();
        req = 4'b1111;
        diff_ready = 1'b1;
        repeat (10) cyc();
        check("rr_count", 32'(grants.size()), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", 32'(grants[k]), 32'(k % N));

        // backpressure: result held with no further grants
        diff_ready = 1'b0;
        repeat (3) cyc();
        grants.delete();
        repeat (5) cyc();
        check("bp_no_gnt", 32'(grants.size()), 0);
        check("bp_valid", 32'(diff_valid), 1);
        diff_ready = 1'b1;
        cyc();
        check("bp_release_gnt", 32'(gnt != 0), 1);
        req = '0;
        repeat (3) cyc();

        // arithmetic boundaries
        do_reset(1);
        set_op(0, 0, 1);
        req = 4'b0001;
        cyc();
        req = '0;
        cyc();
        check("uf_diff", 32'(diff), 32'h3FF);
        check("uf_borrow", 32'(borrow), 1);
        cyc();
        set_op(0, 10'h3FF, 10'h3FF);
        req = 4'b0001;
        cyc();
        req = '0;
        cyc();
        check("eq_diff", 32'(diff), 0);
        check("eq_borrow", 32'(borrow), 0);
        cyc();

        // reset while executing, then while holding
        req = 4'b0010;
        cyc();
        do_reset(1);
        check("rst_exec_valid", 32'(diff_valid), 0);
        req = 4'b1111;
        cyc();
        check("rst_exec_restart", 32'(gnt), 32'h1);
        diff_ready = 1'b0;
        req = '0;
        repeat (2) cyc();
        do_reset(1);
        check("rst_hold_valid", 32'(diff_valid), 0);
        cyc();
        check("rst_hold_idle_gnt", 32'(gnt), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req = N'($urandom);
            for (int k = 0; k < N; k++) set_op(k, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            diff_ready = ($urandom_range(0, 9) < 7);
            Rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        Rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
